// File: rtl/fir_memory_reader_if.sv
// rtl/fir_memory_reader_if.sv - Avalon-MM read port and Avalon-ST source bundle for fir_memory_reader
interface fir_memory_reader_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 64
) ();
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              read;
    logic [DATA_W-1:0] readdata;
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic              src_last;

    modport master (
        output address, chipselect, read,
        input  readdata,
        output src_data, src_valid, src_last,
        input  src_ready
    );

    modport slave (
        input  address, chipselect, read,
        output readdata,
        input  src_data, src_valid, src_last,
        output src_ready
    );
endinterface

// File: rtl/fir_memory_reader.sv
// rtl/fir_memory_reader.sv - block reader: Avalon-MM reads into a FIFO streamed out on Avalon-ST; FIR_READER_LOOP_EN repeats the block forever
module fir_memory_reader #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    fir_memory_reader_if.master bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remaining_q;
    logic              read_q;
    logic              read_last_q;
    logic              rvalid_q;
    logic              rvalid_last_q;
    logic              done_q;
    logic              busy_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W:0]   mem_q [FIFO_DEPTH];
`ifdef FIR_READER_LOOP_EN
    logic [ADDR_W-1:0] cfg_base_q;
    logic [ADDR_W:0]   cfg_len_q;
`endif

    logic             push;
    logic             pop;
    logic             issue;
    logic             issue_last;
    logic             head_last;
    logic             fifo_valid;
    logic [CNT_W-1:0] count_d;

    // Each FIFO entry carries the end-of-pass flag in its top bit.
    assign fifo_valid = (count_q != '0);
    assign push       = rvalid_q;
    assign pop        = fifo_valid && bus.src_ready;
    assign head_last  = mem_q[rd_ptr_q][DATA_W];
    assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

    // A new read is only launched if its word is guaranteed a FIFO slot:
    // next-cycle occupancy plus the read already on the bus plus this one.
    assign issue      = (state_q == RUN) &&
                        ((count_d + CNT_W'(read_q)) < CNT_W'(FIFO_DEPTH));
    assign issue_last = issue && (remaining_q == (ADDR_W+1)'(1));

    assign bus.address    = addr_q;
    assign bus.chipselect = read_q;
    assign bus.read       = read_q;
    assign bus.src_valid  = fifo_valid;
    assign bus.src_data   = fifo_valid ? mem_q[rd_ptr_q][DATA_W-1:0] : '0;
    assign bus.src_last   = fifo_valid && head_last;
    assign busy           = busy_q;
    assign done           = done_q;

    // Control FSM, read pipeline, FIFO pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state_q       <= IDLE;
            read_q        <= 1'b0;
            read_last_q   <= 1'b0;
            rvalid_q      <= 1'b0;
            rvalid_last_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            if (reset) begin
                ptr_q       <= '0;
                addr_q      <= '0;
                remaining_q <= '0;
`ifdef FIR_READER_LOOP_EN
                cfg_base_q  <= '0;
                cfg_len_q   <= '0;
`endif
            end
        end else begin
            done_q        <= 1'b0;
            read_q        <= issue;
            read_last_q   <= issue_last;
            rvalid_q      <= read_q;
            rvalid_last_q <= read_last_q;
            count_q       <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (issue) begin
                addr_q      <= ptr_q;
                ptr_q       <= ptr_q + ADDR_W'(1);
                remaining_q <= remaining_q - (ADDR_W+1)'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q     <= RUN;
                            busy_q      <= 1'b1;
                            ptr_q       <= base_addr;
                            remaining_q <= length;
`ifdef FIR_READER_LOOP_EN
                            cfg_base_q  <= base_addr;
                            cfg_len_q   <= length;
`endif
                        end
                    end
                end
                RUN: begin
                    if (issue_last) begin
`ifdef FIR_READER_LOOP_EN
                        ptr_q       <= cfg_base_q;
                        remaining_q <= cfg_len_q;
`else
                        state_q     <= DRAIN;
`endif
                    end
                end
                DRAIN: begin
                    if (pop && head_last) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // FIFO storage: capture readdata in the cycle after its read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {rvalid_last_q, bus.readdata};
    end
endmodule

// File: tb/tb_fir_memory_reader.sv
// tb/tb_fir_memory_reader.sv - randomized scoreboard bench for fir_memory_reader
module tb_fir_memory_reader;
    localparam int AW    = 14;
    localparam int DW    = 64;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;

    fir_memory_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    fir_memory_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .length(length), .busy(busy), .done(done),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] exp_addr [$];
    logic [DW:0]   exp_data [$];
    int            read_cycles [$];
    int            acc_cycles [$];
    int            reads_total = 0;
    int            accepted = 0;
    int            outstanding = 0;
    bit            done_pipe = 0;
    bit            zero_start = 0;
    int            ready_mode = 0;

    function automatic void chk(string nm, longint unsigned act, longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [DW-1:0] word_of(logic [AW-1:0] a);
        logic [31:0] h;
        h = 32'(a) * 32'h9E37_79B1 + 32'h1234_5678;
        return {16'hC0DE, 2'b00, a, h};
    endfunction

    // Reference model: a transfer is just the word addresses base..base+len-1 modulo 2^AW.
    task automatic model_push(input logic [AW-1:0] b, input int n);
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = AW'((int'(b) + i) % (1 << AW));
            exp_addr.push_back(a);
            exp_data.push_back({(i == n - 1), word_of(a)});
        end
    endtask

    task automatic flush_model();
        exp_addr.delete();
        exp_data.delete();
        outstanding = 0;
    endtask

    // Memory slave with fixed one-cycle read latency; garbage when not read.
    always @(posedge clk) begin
        if (bus_if.chipselect && bus_if.read) bus_if.readdata <= word_of(bus_if.address);
        else bus_if.readdata <= {$urandom(), $urandom()};
    end

    // Sink ready driver: 0 = low, 1 = high, 2 = random, 3 = left to the stimulus.
    initial begin
        bus_if.src_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: bus_if.src_ready = 1'b0;
                1: bus_if.src_ready = 1'b1;
                2: bus_if.src_ready = ($urandom_range(0, 3) != 0);
                default: ;
            endcase
        end
    end

    // Monitor: compares every read address, every accepted word, done timing and hold stability.
    logic          hold_q = 1'b0;
    logic [DW-1:0] hold_data;
    logic          hold_last;
    logic [DW:0]   e;
    always @(negedge clk) begin
        if (reset) begin
            done_pipe  = 1'b0;
            zero_start = 1'b0;
            hold_q     = 1'b0;
        end else begin
            chk("done", done, done_pipe);
            done_pipe = 1'b0;
            if (zero_start) begin
                done_pipe  = 1'b1;
                zero_start = 1'b0;
            end
            if (bus_if.read) begin
                reads_total++;
                outstanding++;
                read_cycles.push_back(cyc);
                chk("chipselect", bus_if.chipselect, 1);
                if (exp_addr.size() == 0) chk("unexpected_read", bus_if.address, 64'hFFFF_FFFF);
                else chk("address", bus_if.address, exp_addr.pop_front());
                chk("occupancy_bound", (outstanding > DEPTH), 0);
            end
            if (bus_if.src_valid && bus_if.src_ready) begin
                accepted++;
                outstanding--;
                acc_cycles.push_back(cyc);
                if (exp_data.size() == 0) begin
                    chk("unexpected_word", bus_if.src_data, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_data.pop_front();
                    chk("src_data", bus_if.src_data, e[DW-1:0]);
                    chk("src_last", bus_if.src_last, e[DW]);
`ifndef FIR_READER_LOOP_EN
                    if (e[DW]) done_pipe = 1'b1;
`endif
                end
            end
            if (hold_q) begin
                chk("hold_valid", bus_if.src_valid, 1);
                chk("hold_data", bus_if.src_data, hold_data);
                chk("hold_last", bus_if.src_last, hold_last);
            end
            hold_q    = bus_if.src_valid && !bus_if.src_ready && !abort;
            hold_data = bus_if.src_data;
            hold_last = bus_if.src_last;
        end
    end

    task automatic start_xfer(input logic [AW-1:0] b, input int n, input bit expect_accept);
        @(posedge clk); #1;
        base_addr = b;
        length    = (AW+1)'(n);
        start     = 1'b1;
        if (expect_accept) begin
            model_push(b, n);
            if (n == 0) zero_start = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string nm);
        int k;
        k = 0;
        while (k < max_cyc) begin
            @(negedge clk);
            if (done === 1'b1) break;
            k++;
        end
        chk({nm, "_done_seen"}, (k < max_cyc), 1);
        chk({nm, "_all_words"}, exp_data.size(), 0);
        @(negedge clk);
        chk({nm, "_busy_after"}, busy, 0);
    endtask

    task automatic check_quiet(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_read"}, bus_if.read, 0);
        chk({nm, "_chipselect"}, bus_if.chipselect, 0);
        chk({nm, "_src_valid"}, bus_if.src_valid, 0);
        chk({nm, "_src_last"}, bus_if.src_last, 0);
        chk({nm, "_address"}, bus_if.address, 0);
        chk({nm, "_src_data"}, bus_if.src_data, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, a0, n;
        logic [AW-1:0] b;
        reset = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        reset = 1'b0;

`ifdef FIR_READER_LOOP_EN
        ready_mode = 1;
        for (int p = 0; p < 40; p++) model_push(14'h0005, 2);
        a0 = accepted;
        start_xfer(14'h0005, 2, 0);
        repeat (30) @(posedge clk);
        #1;
        chk("loop_busy", busy, 1);
        chk("loop_throughput", (accepted - a0 >= 20), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        flush_model();
        chk("loop_abort_valid", bus_if.src_valid, 0);
        chk("loop_abort_busy", busy, 0);
        repeat (8) @(posedge clk);
`else
        // Basic block with consecutive reads and accepts.
        ready_mode = 1;
        read_cycles.delete(); acc_cycles.delete();
        start_xfer(14'h0010, 4, 1);
        chk("basic_busy", busy, 1);
        wait_done(100, "basic");
        chk("basic_reads", read_cycles.size(), 4);
        chk("basic_read_span", read_cycles[3] - read_cycles[0], 3);
        chk("basic_acc_span", acc_cycles[3] - acc_cycles[0], 3);

        // Address wrap at the top of the space.
        start_xfer(14'h3FFE, 3, 1);
        wait_done(100, "wrap");

        // Sustained one word per cycle.
        acc_cycles.delete();
        start_xfer(14'h0200, 12, 1);
        wait_done(100, "stream");
        chk("stream_acc_span", acc_cycles[11] - acc_cycles[0], 11);

        // Back-pressure: only FIFO_DEPTH reads may be outstanding.
        ready_mode = 0;
        @(posedge clk);
        r0 = reads_total; a0 = accepted;
        start_xfer(14'h0100, 10, 1);
        repeat (20) @(posedge clk);
        #1;
        chk("stall_reads", reads_total - r0, DEPTH);
        chk("stall_read_low", bus_if.read, 0);
        ready_mode = 1;
        wait_done(200, "stall");
        chk("stall_words", accepted - a0, 10);

        // Zero length: no read, no busy, done one cycle later.
        r0 = reads_total;
        start_xfer(14'h0040, 0, 1);
        chk("zero_busy", busy, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("zero_reads", reads_total - r0, 0);

        // Abort after two accepted words, then a normal transfer.
        ready_mode = 3;
        bus_if.src_ready = 1'b0;
        start_xfer(14'h0300, 8, 1);
        repeat (8) @(posedge clk);
        #1;
        bus_if.src_ready = 1'b1;
        a0 = accepted;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_if.src_ready = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        flush_model();
        chk("abort_words", accepted - a0, 2);
        chk("abort_valid", bus_if.src_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_read", bus_if.read, 0);
        repeat (6) @(posedge clk);
        ready_mode = 1;
        start_xfer(14'h0020, 2, 1);
        wait_done(100, "after_abort");

        // Reset in the middle of a transfer.
        ready_mode = 0;
        start_xfer(14'h0400, 8, 1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_quiet("midreset");
        @(posedge clk); #1;
        reset = 1'b0;
        flush_model();
        ready_mode = 1;
        r0 = reads_total; a0 = accepted;
        repeat (10) @(posedge clk);
        #1;
        chk("postreset_reads", reads_total - r0, 0);
        chk("postreset_words", accepted - a0, 0);

        // Random transfers with random back-pressure and an ignored start while busy.
        for (int t = 0; t < 8; t++) begin
            ready_mode = 2;
            b = (t == 0) ? 14'h3FF8 : AW'($urandom());
            n = $urandom_range(8, 24);
            start_xfer(b, n, 1);
            repeat (2) @(posedge clk);
            start_xfer(AW'($urandom()), $urandom_range(0, 5), 0);
            wait_done(600, "random");
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
